// File: rtl/mac_accumulator_ctrl.sv
// Accumulates N_TERMS unsigned products from the multiplier into a sticky
// saturating accumulator and offers the final sum over a valid/ready handshake.
module mac_accumulator_ctrl #(
  parameter int PROD_W  = 16,
  parameter int ACC_W   = 24,
  parameter int N_TERMS = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [PROD_W-1:0] prod_in,
  input  logic              prod_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  acc_out,
  output logic              acc_valid,
  output logic              overflow,
  output logic              busy
);

  localparam int CNT_W = $clog2(N_TERMS + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N_TERMS - 1);

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ACC_W:0]   sum;

  // One guard bit above the accumulator catches the carry out for saturation.
  assign sum = {1'b0, acc_q} + {{(ACC_W + 1 - PROD_W){1'b0}}, prod_in};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          acc_d   = '0;
          ovf_d   = 1'b0;
          cnt_d   = '0;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        if (prod_valid) begin
          if (sum[ACC_W] || ovf_q) begin
            acc_d = '1;
            ovf_d = 1'b1;
          end else begin
            acc_d = sum[ACC_W-1:0];
          end
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == LAST) state_d = HOLD;
        end
      end
      HOLD: begin
        // A start coincident with the handshake chains straight into the next run.
        if (out_ready) begin
          if (start) begin
            acc_d   = '0;
            ovf_d   = 1'b0;
            cnt_d   = '0;
            state_d = ACCUM;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign acc_out   = acc_q;
  assign overflow  = ovf_q;
  assign acc_valid = (state_q == HOLD);
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mac_accumulator_ctrl.sv
// Directed bench for mac_accumulator_ctrl: default, narrow-accumulator and
// single-term instances share one stimulus stream.
module tb_mac_accumulator_ctrl;

  logic        clk = 1'b0;
  logic        rst, start, prod_valid, out_ready;
  logic [15:0] prod_in;

  logic [23:0] acc_m;
  logic        vld_m, ovf_m, busy_m;
  logic [16:0] acc_w;
  logic        vld_w, ovf_w, busy_w;
  logic [23:0] acc_n;
  logic        vld_n, ovf_n, busy_n;

  int cmp = 0;
  int err = 0;

  always #5 clk = ~clk;

  mac_accumulator_ctrl u_main (
    .clk(clk), .rst(rst), .start(start), .prod_in(prod_in), .prod_valid(prod_valid),
    .out_ready(out_ready), .acc_out(acc_m), .acc_valid(vld_m), .overflow(ovf_m), .busy(busy_m)
  );

  mac_accumulator_ctrl #(.ACC_W(17)) u_w17 (
    .clk(clk), .rst(rst), .start(start), .prod_in(prod_in), .prod_valid(prod_valid),
    .out_ready(out_ready), .acc_out(acc_w), .acc_valid(vld_w), .overflow(ovf_w), .busy(busy_w)
  );

  mac_accumulator_ctrl #(.N_TERMS(1)) u_n1 (
    .clk(clk), .rst(rst), .start(start), .prod_in(prod_in), .prod_valid(prod_valid),
    .out_ready(out_ready), .acc_out(acc_n), .acc_valid(vld_n), .overflow(ovf_n), .busy(busy_n)
  );

  // Inputs change 1 time unit after a rising edge; outputs are read there too.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; prod_valid = 1'b0; out_ready = 1'b0; prod_in = '0;
    cyc();
    rst = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic push(input logic [15:0] p);
    prod_valid = 1'b1; prod_in = p;
    cyc();
    prod_valid = 1'b0;
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    cmp++; if (acc_m !== 24'h0) begin err++; $display("FAIL reset_acc got %h exp %h", acc_m, 24'h0); end
    cmp++; if ({vld_m, ovf_m, busy_m} !== 3'b000) begin err++; $display("FAIL reset_flags got %b exp 000", {vld_m, ovf_m, busy_m}); end
  endtask

  task automatic test_full_run();
    do_start();
    cmp++; if (busy_m !== 1'b1 || acc_m !== 24'h0) begin err++; $display("FAIL t1_start got busy=%b acc=%h exp busy=1 acc=0", busy_m, acc_m); end
    for (int i = 0; i < 8; i++) begin
      push(16'hFE01);
      if (i < 7) begin
        cmp++; if (vld_m !== 1'b0) begin err++; $display("FAIL t1_early_valid got %b exp 0 at term %0d", vld_m, i); end
      end
    end
    cmp++; if (vld_m !== 1'b1) begin err++; $display("FAIL t1_valid got %b exp 1", vld_m); end
    cmp++; if (acc_m !== 24'h07F008) begin err++; $display("FAIL t1_acc got %h exp %h", acc_m, 24'h07F008); end
    cmp++; if (ovf_m !== 1'b0 || busy_m !== 1'b1) begin err++; $display("FAIL t1_flags got ovf=%b busy=%b exp ovf=0 busy=1", ovf_m, busy_m); end
    handshake();
    cmp++; if ({vld_m, busy_m} !== 2'b00) begin err++; $display("FAIL t1_release got vld/busy %b exp 00", {vld_m, busy_m}); end
    cmp++; if (acc_m !== 24'h07F008) begin err++; $display("FAIL t1_acc_kept got %h exp %h", acc_m, 24'h07F008); end
  endtask

  task automatic test_gaps();
    push(16'h0005);
    cmp++; if (acc_m !== 24'h07F008 || busy_m !== 1'b0) begin err++; $display("FAIL t2_idle_pulse got acc=%h busy=%b exp acc=07f008 busy=0", acc_m, busy_m); end
    do_start();
    for (int i = 1; i <= 8; i++) begin
      for (int g = 0; g < (i % 4); g++) cyc();
      push(16'(i));
      if (i < 8) begin
        cmp++; if (vld_m !== 1'b0) begin err++; $display("FAIL t2_early_valid got %b exp 0 at term %0d", vld_m, i); end
      end
    end
    cmp++; if (vld_m !== 1'b1 || acc_m !== 24'h000024) begin err++; $display("FAIL t2_sum got vld=%b acc=%h exp vld=1 acc=000024", vld_m, acc_m); end
    handshake();
  endtask

  task automatic test_saturate();
    do_reset();
    do_start();
    push(16'hFE01);
    push(16'hFE01);
    cmp++; if (acc_w !== 17'h1FC02 || ovf_w !== 1'b0) begin err++; $display("FAIL t3_two got acc=%h ovf=%b exp 1fc02 0", acc_w, ovf_w); end
    push(16'hFE01);
    cmp++; if (acc_w !== 17'h1FFFF || ovf_w !== 1'b1) begin err++; $display("FAIL t3_sat got acc=%h ovf=%b exp 1ffff 1", acc_w, ovf_w); end
    for (int i = 0; i < 5; i++) push(16'h0001);
    cmp++; if (acc_w !== 17'h1FFFF || ovf_w !== 1'b1 || vld_w !== 1'b1) begin err++; $display("FAIL t3_final got acc=%h ovf=%b vld=%b exp 1ffff 1 1", acc_w, ovf_w, vld_w); end
    cmp++; if (acc_m !== 24'h02FA08 || ovf_m !== 1'b0) begin err++; $display("FAIL t3_wide got acc=%h ovf=%b exp 02fa08 0", acc_m, ovf_m); end
    handshake();
  endtask

  task automatic test_backpressure();
    do_reset();
    do_start();
    for (int i = 0; i < 8; i++) push(16'h0010);
    for (int i = 0; i < 5; i++) begin
      start = i[0]; prod_valid = ~i[0]; prod_in = 16'hFFFF; out_ready = 1'b0;
      cyc();
      cmp++; if (acc_m !== 24'h000080 || vld_m !== 1'b1 || ovf_m !== 1'b0) begin err++; $display("FAIL t4_hold got acc=%h vld=%b ovf=%b exp 000080 1 0", acc_m, vld_m, ovf_m); end
    end
    start = 1'b1; prod_valid = 1'b0; out_ready = 1'b1;
    cyc();
    start = 1'b0; out_ready = 1'b0;
    cmp++; if (vld_m !== 1'b0 || acc_m !== 24'h0 || busy_m !== 1'b1) begin err++; $display("FAIL t4_chain got vld=%b acc=%h busy=%b exp 0 0 1", vld_m, acc_m, busy_m); end
    for (int i = 0; i < 8; i++) push(16'h0003);
    cmp++; if (vld_m !== 1'b1 || acc_m !== 24'h000018) begin err++; $display("FAIL t4_rerun got vld=%b acc=%h exp 1 000018", vld_m, acc_m); end
    handshake();
  endtask

  task automatic test_mid_reset();
    do_reset();
    do_start();
    for (int i = 0; i < 3; i++) push(16'h0100);
    cmp++; if (acc_m !== 24'h000300) begin err++; $display("FAIL t5_partial got %h exp 000300", acc_m); end
    do_reset();
    cmp++; if (acc_m !== 24'h0 || busy_m !== 1'b0 || vld_m !== 1'b0) begin err++; $display("FAIL t5_reset got acc=%h busy=%b vld=%b exp 0 0 0", acc_m, busy_m, vld_m); end
    push(16'h0100);
    push(16'h0100);
    cmp++; if (acc_m !== 24'h0 || busy_m !== 1'b0) begin err++; $display("FAIL t5_ignored got acc=%h busy=%b exp 0 0", acc_m, busy_m); end
    do_start();
    for (int i = 0; i < 8; i++) push(16'h0100);
    cmp++; if (acc_m !== 24'h000800 || vld_m !== 1'b1) begin err++; $display("FAIL t5_rerun got acc=%h vld=%b exp 000800 1", acc_m, vld_m); end
    handshake();
  endtask

  task automatic test_single_term();
    do_reset();
    do_start();
    push(16'h1234);
    cmp++; if (vld_n !== 1'b1 || acc_n !== 24'h001234 || busy_n !== 1'b1) begin err++; $display("FAIL t6_one got vld=%b acc=%h busy=%b exp 1 001234 1", vld_n, acc_n, busy_n); end
    handshake();
    cmp++; if (busy_n !== 1'b0 || vld_n !== 1'b0) begin err++; $display("FAIL t6_idle got busy=%b vld=%b exp 0 0", busy_n, vld_n); end
  endtask

  initial begin
    test_reset();
    test_full_run();
    test_gaps();
    test_saturate();
    test_backpressure();
    test_mid_reset();
    test_single_term();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
    $finish;
  end

endmodule
